// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// The divider is only built when MCYCLE_DIV_EN is defined (see mcycle_datapath).
package mcycle_pkg;

    localparam int MCYCLE_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_FIXUP   = 2'b10,
        ST_DONE    = 2'b11
    } mcycle_state_e;

    // R15 is never a multi-cycle destination, so it is a safe idle value for the hazard compares.
    localparam logic [3:0] WA3_RESET = 4'hF;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mcycle_datapath.sv
// Shift-add multiplier / restoring divider working on operand magnitudes, plus sign fixup.
// Divider logic is built only when MCYCLE_DIV_EN is defined; otherwise divide ops return all ones.
module mcycle_datapath
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fixup,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2
);

    localparam int DW = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value, input logic is_signed);
        logic [WIDTH-1:0] mag;
        if (is_signed && value[WIDTH-1]) begin
            mag = ~value + WIDTH'(1);
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    function automatic logic [WIDTH-1:0] negate_word(input logic [WIDTH-1:0] value, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~value + WIDTH'(1);
        end else begin
            res = value;
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] negate_dword(input logic [DW-1:0] value, input logic neg);
        logic [DW-1:0] res;
        if (neg) begin
            res = ~value + DW'(1);
        end else begin
            res = value;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] acc_hi_r, acc_lo_r, mcand_r;
    logic             neg_lo_r;
    logic [WIDTH-1:0] result1_r, result2_r;

    logic             is_signed_s, neg_lo_s, div_fill_s;
    logic [WIDTH-1:0] mag1_s, mag2_s, load_lo_s, load_mcand_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic [DW-1:0]    prod_s;
    logic [WIDTH-1:0] fix1_s, fix2_s;

`ifdef MCYCLE_DIV_EN
    logic             is_div_r, neg_hi_r;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
`endif

    assign is_signed_s = op_is_signed(op);
    assign mag1_s      = magnitude(operand1, is_signed_s);
    assign mag2_s      = magnitude(operand2, is_signed_s);

`ifdef MCYCLE_DIV_EN
    assign div_fill_s = 1'b0;
`else
    assign div_fill_s = load & op_is_div(op);
`endif

    // Operand placement at accept: multiplier/dividend go into the low word that gets shifted.
    always_comb begin
        load_lo_s    = mag2_s;
        load_mcand_s = mag1_s;
        neg_lo_s     = is_signed_s & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
        if (op_is_div(op)) begin
            load_lo_s    = mag1_s;
            load_mcand_s = mag2_s;
            // A zero divisor must yield an all-ones quotient, so it never takes a sign.
            neg_lo_s     = is_signed_s & (operand1[WIDTH-1] ^ operand2[WIDTH-1]) & (operand2 != {WIDTH{1'b0}});
        end else begin
            load_lo_s    = mag2_s;
            load_mcand_s = mag1_s;
        end
`endif
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        step_hi_s = mul_sum_s[WIDTH:1];
        step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, mcand_r};
        if (is_div_r) begin
            if (div_diff_s[WIDTH+1]) begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end else begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
`endif
    end

    // Sign correction; the remainder follows the dividend's sign.
    always_comb begin
        prod_s = negate_dword({acc_hi_r, acc_lo_r}, neg_lo_r);
        fix1_s = prod_s[WIDTH-1:0];
        fix2_s = prod_s[DW-1:WIDTH];
`ifdef MCYCLE_DIV_EN
        if (is_div_r) begin
            fix1_s = negate_word(acc_lo_r, neg_lo_r);
            fix2_s = negate_word(acc_hi_r, neg_hi_r);
        end else begin
            fix1_s = prod_s[WIDTH-1:0];
            fix2_s = prod_s[DW-1:WIDTH];
        end
`endif
    end

    // Working registers: loaded at accept, advanced once per compute cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            neg_lo_r <= 1'b0;
`ifdef MCYCLE_DIV_EN
            is_div_r <= 1'b0;
            neg_hi_r <= 1'b0;
`endif
        end else if (load) begin
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= load_lo_s;
            mcand_r  <= load_mcand_s;
            neg_lo_r <= neg_lo_s;
`ifdef MCYCLE_DIV_EN
            is_div_r <= op_is_div(op);
            neg_hi_r <= is_signed_s & operand1[WIDTH-1];
`endif
        end else if (step) begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
        end
    end

    // Result registers hold between operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result1_r <= {WIDTH{1'b0}};
            result2_r <= {WIDTH{1'b0}};
        end else if (div_fill_s) begin
            result1_r <= {WIDTH{1'b1}};
            result2_r <= {WIDTH{1'b1}};
        end else if (fixup) begin
            result1_r <= fix1_s;
            result2_r <= fix2_s;
        end
    end

    assign result1 = result1_r;
    assign result2 = result2_r;

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: control FSM, iteration counter and hazard-facing status.
// Define MCYCLE_DIV_EN to build the divider; without it divide ops complete immediately with all ones.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
)
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       WA3,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       MCycleWA3
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mcycle_state_e    state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             load_s, step_s, fixup_s;
    logic             busy_r, done_r;
    logic [3:0]       wa3_r;

    // Next-state and datapath strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        fixup_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    load_s = 1'b1;
`ifdef MCYCLE_DIV_EN
                    next_state_s = ST_COMPUTE;
`else
                    next_state_s = op_is_div(MCycleOp) ? ST_DONE : ST_COMPUTE;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_FIXUP;
                end else begin
                    next_state_s = ST_COMPUTE;
                end
            end
            ST_FIXUP: begin
                fixup_s      = 1'b1;
                next_state_s = ST_DONE;
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State plus registered Busy/Done, decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wa3_r   <= WA3_RESET;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_COMPUTE) || (next_state_s == ST_FIXUP);
            done_r  <= (next_state_s == ST_DONE);
            if (load_s) begin
                wa3_r <= WA3;
            end
        end
    end

    // Iteration counter, cleared at accept.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    mcycle_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (load_s),
        .step     (step_s),
        .fixup    (fixup_s),
        .op       (MCycleOp),
        .operand1 (Operand1),
        .operand2 (Operand2),
        .result1  (Result1),
        .result2  (Result2)
    );

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign MCycleWA3 = wa3_r;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed corner cases plus randomized operations
// against an arithmetic reference model. Expectations follow MCYCLE_DIV_EN when defined.
module tb_mcycle_unit;

    localparam int W = 32;

`ifdef MCYCLE_DIV_EN
    localparam bit DIV_BUILT = 1'b1;
`else
    localparam bit DIV_BUILT = 1'b0;
`endif

    logic         CLK, RESET, Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1, Operand2, Result1, Result2;
    logic [3:0]   WA3, MCycleWA3;
    logic         Busy, Done;

    int checks   = 0;
    int failures = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Start     (Start),
        .MCycleOp  (MCycleOp),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .WA3       (WA3),
        .Result1   (Result1),
        .Result2   (Result2),
        .Busy      (Busy),
        .Done      (Done),
        .MCycleWA3 (MCycleWA3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {Result2, Result1} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p, q, r;
        logic [63:0] ua, ub, u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: begin
                u = ua * ub;
                return u;
            end
            default: begin
                if (!DIV_BUILT) return {64{1'b1}};
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                u = {(ua % ub), 32'h0} | (ua / ub);
                return u;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op in the current cycle (cycle 0) and watch it until one cycle past Done.
    // Inputs are scrambled after accept; 'stray' pulses Start in cycles 5 and WIDTH+2.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] wa, input bit stray, input string name);
        logic [63:0] exp;
        logic [31:0] r1, r2;
        logic [3:0]  wa_seen;
        int          exp_done, win, dones, first_done, busy_bad;
        bit          div_skip, exp_busy;
        exp        = ref_result(op, a, b);
        div_skip   = op[1] && !DIV_BUILT;
        exp_done   = div_skip ? 1 : W + 2;
        win        = exp_done + 1;
        dones      = 0;
        first_done = -1;
        busy_bad   = 0;
        r1         = 32'h0;
        r2         = 32'h0;
        wa_seen    = 4'h0;
        Start      = 1'b1;
        MCycleOp   = op;
        Operand1   = a;
        Operand2   = b;
        WA3        = wa;
        for (int c = 1; c <= win; c++) begin
            @(negedge CLK);
            exp_busy = !div_skip && (c <= W + 1);
            if (Busy !== exp_busy) busy_bad++;
            if (Done === 1'b1) begin
                dones++;
                if (first_done < 0) begin
                    first_done = c;
                    r1         = Result1;
                    r2         = Result2;
                    wa_seen    = MCycleWA3;
                end
            end
            Start    = stray && (c == 5 || c == W + 2);
            MCycleOp = 2'($urandom_range(0, 3));
            Operand1 = $urandom();
            Operand2 = $urandom();
            WA3      = 4'($urandom_range(0, 15));
        end
        Start = 1'b0;
        check_val({name, ".done_cycle"}, 64'(first_done), 64'(exp_done));
        check_val({name, ".done_count"}, 64'(dones), 64'd1);
        check_val({name, ".busy_bad"}, 64'(busy_bad), 64'd0);
        check_val({name, ".result1"}, {32'h0, r1}, {32'h0, exp[31:0]});
        check_val({name, ".result2"}, {32'h0, r2}, {32'h0, exp[63:32]});
        check_val({name, ".wa3"}, {60'h0, wa_seen}, {60'h0, wa});
    endtask

    // Abort an operation with RESET in cycle 10, try a Start while in reset, then confirm silence.
    task automatic reset_abort();
        int dones;
        Start    = 1'b1;
        MCycleOp = DIV_BUILT ? 2'b10 : 2'b01;
        Operand1 = 32'd1000;
        Operand2 = 32'd7;
        WA3      = 4'd4;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        RESET = 1'b0;
        @(negedge CLK);
        check_val("abort.busy", {63'h0, Busy}, 64'd0);
        check_val("abort.done", {63'h0, Done}, 64'd0);
        check_val("abort.wa3", {60'h0, MCycleWA3}, 64'hF);
        check_val("abort.result1", {32'h0, Result1}, 64'd0);
        check_val("abort.result2", {32'h0, Result2}, 64'd0);
        Start = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        Start = 1'b0;
        check_val("abort.start_in_reset", {63'h0, Busy}, 64'd0);
        dones = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge CLK);
            if (Done === 1'b1) dones++;
        end
        check_val("abort.no_done", 64'(dones), 64'd0);
    endtask

    initial begin
        RESET    = 1'b0;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        WA3      = 4'h0;
        repeat (3) @(negedge CLK);
        check_val("reset.busy", {63'h0, Busy}, 64'd0);
        check_val("reset.done", {63'h0, Done}, 64'd0);
        check_val("reset.result1", {32'h0, Result1}, 64'd0);
        check_val("reset.result2", {32'h0, Result2}, 64'd0);
        check_val("reset.wa3", {60'h0, MCycleWA3}, 64'hF);
        RESET = 1'b1;
        @(negedge CLK);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b0, "umul_max");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 4'd5, 1'b0, "smul_neg7x6");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd6, 1'b0, "sdiv_neg7by2");
        run_op(2'b11, 32'd100, 32'd0, 4'd7, 1'b0, "udiv_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 1'b0, "sdiv_min_m1");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 4'd9, 1'b0, "sdiv_neg_by0");
        run_op(2'b01, 32'd12345, 32'd6789, 4'd3, 1'b1, "stray_start");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 4'd2, 1'b0, "smul_min_min");
        run_op(2'b11, 32'hDEAD_BEEF, 32'd17, 4'd1, 1'b0, "udiv_basic");
        run_op(2'b01, 32'd7, 32'd9, 4'd10, 1'b0, "umul_small");

        reset_abort();
        run_op(2'b01, 32'd300, 32'd5, 4'd11, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   4'($urandom_range(0, 14)), ($urandom_range(0, 7) == 0), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
